// File: rtl/axi_master_bridge_if.sv
// Signal bundle for axi_master_bridge: local request/stream port plus the five AXI4 channels.
// The master modport is the bridge's view; the slave modport is the environment's view.
interface axi_master_bridge_if #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_W-1:0]     req_addr;
    logic [LEN_W-1:0]      req_len;
    logic                  wd_valid;
    logic [DATA_W-1:0]     wd_data;
    logic [DATA_W/8-1:0]   wd_strb;
    logic                  wd_ready;
    logic                  rd_valid;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_last;
    logic                  done;
    logic [1:0]            done_resp;

    logic [ID_W-1:0]       ARID;
    logic [ADDR_W-1:0]     ARADDR;
    logic [LEN_W-1:0]      ARLEN;
    logic [2:0]            ARSIZE;
    logic [1:0]            ARBURST;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [ID_W-1:0]       RID;
    logic [DATA_W-1:0]     RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;
    logic [ID_W-1:0]       AWID;
    logic [ADDR_W-1:0]     AWADDR;
    logic [LEN_W-1:0]      AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_W-1:0]     WDATA;
    logic [DATA_W/8-1:0]   WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;
    logic [ID_W-1:0]       BID;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    modport master (
        input  req_valid, req_write, req_addr, req_len, wd_valid, wd_data, wd_strb,
        output req_ready, wd_ready, rd_valid, rd_data, rd_last, done, done_resp,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len, wd_valid, wd_data, wd_strb,
        input  req_ready, wd_ready, rd_valid, rd_data, rd_last, done, done_resp,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/axi_master_bridge.sv
// AXI4 initiator: turns one local read/write request at a time into an INCR burst on the
// AR/R or AW/W/B channels and reports the worst response with a one-cycle done pulse.
module axi_master_bridge #(
    parameter int unsigned     ID_W   = 4,
    parameter int unsigned     ADDR_W = 32,
    parameter int unsigned     DATA_W = 32,
    parameter int unsigned     LEN_W  = 4,
    parameter logic [ID_W-1:0] MST_ID = '0
) (
    input logic                 ACLK,
    input logic                 ARESETn,
    axi_master_bridge_if.master bus
);
    localparam logic [2:0] AxSize  = 3'($clog2(DATA_W / 8));
    localparam logic [1:0] RespOk  = 2'b00;
    localparam logic [1:0] RespSlv = 2'b10;

    typedef enum logic [2:0] {StIdle, StAr, StR, StAw, StW, StB} state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_done;
    logic [1:0]        r_resp;

    logic              w_req_acc;
    logic              w_r_beat;
    logic              w_w_beat;
    logic              w_cnt_last;
    logic [1:0]        w_beat_resp;
    logic [1:0]        w_resp_fold;

    assign w_cnt_last = (r_cnt == r_len);
    assign w_req_acc  = bus.req_valid && bus.req_ready;
    assign w_r_beat   = (r_state == StR) && bus.RVALID;
    assign w_w_beat   = (r_state == StW) && bus.wd_valid && bus.WREADY;

    // Foreign IDs and a burst length disagreeing with RLAST both count as SLVERR.
    always_comb begin
        if (r_state == StB) begin
            w_beat_resp = (bus.BID != MST_ID) ? RespSlv : bus.BRESP;
        end else begin
            w_beat_resp = (bus.RID != MST_ID) ? RespSlv : bus.RRESP;
            if (bus.RLAST && !w_cnt_last && (w_beat_resp < RespSlv)) begin
                w_beat_resp = RespSlv;
            end
        end
        w_resp_fold = (w_beat_resp > r_resp) ? w_beat_resp : r_resp;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (w_req_acc) w_state_nxt = bus.req_write ? StAw : StAr;
            StAr:    if (bus.ARREADY) w_state_nxt = StR;
            StR:     if (bus.RVALID && bus.RLAST) w_state_nxt = StIdle;
            StAw:    if (bus.AWREADY) w_state_nxt = StW;
            StW:     if (w_w_beat && w_cnt_last) w_state_nxt = StB;
            StB:     if (bus.BVALID) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_resp  <= RespOk;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_req_acc) begin
                        r_addr <= bus.req_addr;
                        r_len  <= bus.req_len;
                        r_cnt  <= '0;
                        r_resp <= RespOk;
                    end
                end
                StR: begin
                    if (bus.RVALID) begin
                        r_resp <= w_resp_fold;
                        r_cnt  <= bus.RLAST ? '0 : r_cnt + LEN_W'(1);
                        r_done <= bus.RLAST;
                    end
                end
                StW: begin
                    if (w_w_beat) r_cnt <= w_cnt_last ? '0 : r_cnt + LEN_W'(1);
                end
                StB: begin
                    if (bus.BVALID) begin
                        r_resp <= w_resp_fold;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Held low during the done cycle so a new request lands the cycle after done.
    assign bus.req_ready = (r_state == StIdle) && !r_done && ARESETn;
    assign bus.done      = r_done;
    assign bus.done_resp = r_resp;

    assign bus.ARID    = MST_ID;
    assign bus.ARADDR  = r_addr;
    assign bus.ARLEN   = r_len;
    assign bus.ARSIZE  = AxSize;
    assign bus.ARBURST = 2'b01;
    assign bus.ARVALID = (r_state == StAr);

    assign bus.RREADY   = (r_state == StR);
    assign bus.rd_valid = w_r_beat;
    assign bus.rd_data  = bus.RDATA;
    assign bus.rd_last  = w_r_beat && bus.RLAST;

    assign bus.AWID    = MST_ID;
    assign bus.AWADDR  = r_addr;
    assign bus.AWLEN   = r_len;
    assign bus.AWSIZE  = AxSize;
    assign bus.AWBURST = 2'b01;
    assign bus.AWVALID = (r_state == StAw);

    assign bus.WVALID   = (r_state == StW) && bus.wd_valid;
    assign bus.WDATA    = bus.wd_data;
    assign bus.WSTRB    = bus.wd_strb;
    assign bus.WLAST    = (r_state == StW) && w_cnt_last;
    assign bus.wd_ready = (r_state == StW) && bus.WREADY;

    assign bus.BREADY = (r_state == StB);
endmodule

// File: tb/tb_axi_master_bridge.sv
// Self-checking bench for axi_master_bridge: the bench plays both the local requester and
// the AXI slave, with read/write data scoreboards fed as stimulus is driven.
module tb_axi_master_bridge;
    logic ACLK    = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    axi_master_bridge_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .LEN_W(4)) bus ();

    axi_master_bridge #(
        .ID_W(4), .ADDR_W(32), .DATA_W(32), .LEN_W(4), .MST_ID(4'h0)
    ) dut (
        .ACLK(ACLK),
        .ARESETn(ARESETn),
        .bus(bus)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] rd_q[$];
    logic [36:0] wr_q[$];
    logic        both_seen = 1'b0;

    always @(posedge ACLK) if (bus.ARVALID && bus.AWVALID) both_seen <= 1'b1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got hang want finish");
        $fatal(1);
    end

    task automatic init_bus();
        bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0; bus.req_len = '0;
        bus.wd_valid = 0; bus.wd_data = '0; bus.wd_strb = '0;
        bus.ARREADY = 0; bus.RVALID = 0; bus.RID = '0; bus.RDATA = '0; bus.RRESP = '0;
        bus.RLAST = 0; bus.AWREADY = 0; bus.WREADY = 0;
        bus.BVALID = 0; bus.BID = '0; bus.BRESP = '0;
    endtask

    task automatic send_req(input bit wr, input logic [31:0] addr, input logic [3:0] len);
        int k = 0;
        @(negedge ACLK);
        bus.req_valid = 1; bus.req_write = wr; bus.req_addr = addr; bus.req_len = len;
        #1;
        while (!bus.req_ready && k < 20) begin @(negedge ACLK); #1; k++; end
        n_total++;
        if (bus.req_ready !== 1'b1) $display("FAIL req_accept: got %b want 1", bus.req_ready);
        else n_pass++;
        @(negedge ACLK);
        bus.req_valid = 0;
    endtask

    task automatic ar_phase(input logic [31:0] addr, input logic [3:0] len, input int wt);
        int nv = 0;
        for (int c = 0; c <= wt; c++) begin
            if (c > 0) @(negedge ACLK);
            bus.ARREADY = (c == wt);
            #1;
            if (bus.ARVALID) nv++;
        end
        n_total++;
        if (nv != wt + 1) $display("FAIL arvalid_hold: got %0d cycles want %0d", nv, wt + 1);
        else n_pass++;
        n_total++;
        if ({bus.ARADDR, bus.ARLEN, bus.ARSIZE, bus.ARBURST, bus.ARID} !==
            {addr, len, 3'd2, 2'b01, 4'h0})
            $display("FAIL ar_fields: got addr %h len %0d size %0d burst %0d id %0d want addr %h len %0d size 2 burst 1 id 0",
                     bus.ARADDR, bus.ARLEN, bus.ARSIZE, bus.ARBURST, bus.ARID, addr, len);
        else n_pass++;
        @(negedge ACLK);
        bus.ARREADY = 0;
    endtask

    task automatic aw_phase(input logic [31:0] addr, input logic [3:0] len, input int wt);
        int nv = 0;
        int bad = 0;
        bus.wd_valid = 1; bus.wd_data = 32'hBAD0_BAD0; bus.WREADY = 1;
        for (int c = 0; c <= wt; c++) begin
            if (c > 0) @(negedge ACLK);
            bus.AWREADY = (c == wt);
            #1;
            if (bus.AWVALID) nv++;
            if (bus.WVALID || bus.wd_ready || bus.ARVALID) bad++;
        end
        n_total++;
        if (nv != wt + 1) $display("FAIL awvalid_hold: got %0d cycles want %0d", nv, wt + 1);
        else n_pass++;
        n_total++;
        if (bad != 0) $display("FAIL w_before_aw: got %0d cycles with W/AR activity want 0", bad);
        else n_pass++;
        n_total++;
        if ({bus.AWADDR, bus.AWLEN, bus.AWSIZE, bus.AWBURST, bus.AWID} !==
            {addr, len, 3'd2, 2'b01, 4'h0})
            $display("FAIL aw_fields: got addr %h len %0d size %0d burst %0d id %0d want addr %h len %0d",
                     bus.AWADDR, bus.AWLEN, bus.AWSIZE, bus.AWBURST, bus.AWID, addr, len);
        else n_pass++;
        @(negedge ACLK);
        bus.AWREADY = 0; bus.wd_valid = 0; bus.WREADY = 0;
    endtask

    task automatic check_done(input logic [1:0] exp_resp, input string name);
        #1;
        n_total++;
        if ({bus.done, bus.req_ready, bus.done_resp} !== {1'b1, 1'b0, exp_resp})
            $display("FAIL %s_done: got done %b req_ready %b resp %b want done 1 req_ready 0 resp %b",
                     name, bus.done, bus.req_ready, bus.done_resp, exp_resp);
        else n_pass++;
        @(negedge ACLK);
        #1;
        n_total++;
        if ({bus.done, bus.req_ready} !== 2'b01)
            $display("FAIL %s_after_done: got done %b req_ready %b want done 0 req_ready 1",
                     name, bus.done, bus.req_ready);
        else n_pass++;
    endtask

    task automatic r_burst(input int nbeats, input int err_beat, input logic [1:0] err_resp,
                           input int id_beat, input logic [31:0] base,
                           input logic [1:0] exp_resp, input string name);
        int          nrd = 0;
        logic [31:0] e;
        for (int i = 0; i < nbeats; i++) begin
            @(negedge ACLK);
            if (i % 3 == 2) begin
                bus.RVALID = 0; bus.RLAST = 0;
                @(negedge ACLK);
            end
            bus.RVALID = 1;
            bus.RDATA  = base + 32'(i);
            bus.RRESP  = (i == err_beat) ? err_resp : 2'b00;
            bus.RID    = (i == id_beat) ? 4'h5 : 4'h0;
            bus.RLAST  = (i == nbeats - 1);
            rd_q.push_back(base + 32'(i));
            #1;
            if (bus.rd_valid) begin
                nrd++;
                e = rd_q.pop_front();
                n_total++;
                if ({bus.rd_data, bus.rd_last, bus.RREADY} !== {e, bus.RLAST, 1'b1})
                    $display("FAIL %s_rd_beat%0d: got data %h last %b rready %b want data %h last %b rready 1",
                             name, i, bus.rd_data, bus.rd_last, bus.RREADY, e, bus.RLAST);
                else n_pass++;
            end
        end
        @(negedge ACLK);
        bus.RVALID = 0; bus.RLAST = 0; bus.RID = '0; bus.RRESP = '0;
        n_total++;
        if (nrd != nbeats || rd_q.size() != 0)
            $display("FAIL %s_rd_count: got %0d pulses (%0d unmatched) want %0d",
                     name, nrd, rd_q.size(), nbeats);
        else n_pass++;
        rd_q.delete();
        check_done(exp_resp, name);
    endtask

    task automatic w_burst(input int len, input logic [1:0] bresp, input logic [3:0] bid,
                           input logic [1:0] exp_resp, input string name);
        int          hs = 0;
        logic [36:0] e;
        fork
            begin
                for (int i = 0; i <= len; i++) begin
                    int k = 0;
                    @(negedge ACLK);
                    if (i % 2 == 1) begin bus.wd_valid = 0; @(negedge ACLK); end
                    bus.wd_valid = 1;
                    bus.wd_data  = 32'(i + 1);
                    bus.wd_strb  = 4'hF ^ 4'(i);
                    wr_q.push_back({32'(i + 1), 4'hF ^ 4'(i), i == len});
                    #1;
                    while (!bus.wd_ready && k < 50) begin @(negedge ACLK); #1; k++; end
                end
                @(negedge ACLK);
                bus.wd_valid = 0;
            end
            begin
                int cyc = 0;
                while (hs < len + 1 && cyc < 100) begin
                    @(negedge ACLK);
                    bus.WREADY = (cyc % 3 != 1);
                    cyc++;
                    #1;
                    if (bus.WVALID && bus.WREADY) begin
                        e = wr_q.pop_front();
                        hs++;
                        n_total++;
                        if ({bus.WDATA, bus.WSTRB, bus.WLAST} !== e)
                            $display("FAIL %s_w_beat%0d: got data %h strb %h last %b want data %h strb %h last %b",
                                     name, hs, bus.WDATA, bus.WSTRB, bus.WLAST, e[36:5], e[4:1], e[0]);
                        else n_pass++;
                    end
                end
                @(negedge ACLK);
                bus.WREADY = 0;
            end
        join
        n_total++;
        if (hs != len + 1) $display("FAIL %s_w_count: got %0d handshakes want %0d", name, hs, len + 1);
        else n_pass++;
        wr_q.delete();
        @(negedge ACLK);
        bus.BVALID = 1; bus.BRESP = bresp; bus.BID = bid;
        #1;
        n_total++;
        if ({bus.BREADY, bus.WVALID} !== 2'b10)
            $display("FAIL %s_bready: got bready %b wvalid %b want bready 1 wvalid 0",
                     name, bus.BREADY, bus.WVALID);
        else n_pass++;
        @(negedge ACLK);
        bus.BVALID = 0; bus.BRESP = '0; bus.BID = '0;
        check_done(exp_resp, name);
    endtask

    task automatic test_reset();
        init_bus();
        ARESETn = 0;
        repeat (3) @(negedge ACLK);
        #1;
        n_total++;
        if ({bus.ARVALID, bus.AWVALID, bus.WVALID, bus.RREADY, bus.BREADY, bus.rd_valid,
             bus.done, bus.wd_ready, bus.req_ready, bus.done_resp} !== 11'b0)
            $display("FAIL reset_outputs: got ar %b aw %b w %b r %b b %b rd %b done %b wdr %b rq %b resp %b want all 0",
                     bus.ARVALID, bus.AWVALID, bus.WVALID, bus.RREADY, bus.BREADY, bus.rd_valid,
                     bus.done, bus.wd_ready, bus.req_ready, bus.done_resp);
        else n_pass++;
        @(negedge ACLK);
        ARESETn = 1;
        #1;
        n_total++;
        if (bus.req_ready !== 1'b1) $display("FAIL reset_idle_ready: got %b want 1", bus.req_ready);
        else n_pass++;
    endtask

    task automatic test_single_read();
        send_req(0, 32'h1000, 4'd0);
        ar_phase(32'h1000, 4'd0, 2);
        r_burst(1, -1, 2'b00, -1, 32'hDEAD_BEEF, 2'b00, "single_read");
    endtask

    task automatic test_write_burst();
        send_req(1, 32'h2000, 4'd3);
        aw_phase(32'h2000, 4'd3, 1);
        w_burst(3, 2'b00, 4'h0, 2'b00, "write4");
    endtask

    task automatic test_read_slverr();
        send_req(0, 32'h4000, 4'd7);
        ar_phase(32'h4000, 4'd7, 0);
        r_burst(8, 3, 2'b10, -1, 32'hA000_0000, 2'b10, "read8_slverr");
    endtask

    task automatic test_early_rlast();
        send_req(0, 32'h3000, 4'd3);
        ar_phase(32'h3000, 4'd3, 1);
        r_burst(2, -1, 2'b00, -1, 32'h0000_00B0, 2'b10, "early_rlast");
        send_req(0, 32'h3100, 4'd1);
        ar_phase(32'h3100, 4'd1, 0);
        r_burst(2, -1, 2'b00, -1, 32'h0000_00C0, 2'b00, "after_early");
    endtask

    task automatic test_id_mismatch();
        send_req(0, 32'h6000, 4'd1);
        ar_phase(32'h6000, 4'd1, 0);
        r_burst(2, -1, 2'b00, 0, 32'h6600_0000, 2'b10, "rid_mismatch");
        send_req(1, 32'h6100, 4'd0);
        aw_phase(32'h6100, 4'd0, 0);
        w_burst(0, 2'b00, 4'h3, 2'b10, "bid_mismatch");
    endtask

    task automatic test_back_to_back();
        both_seen = 1'b0;
        send_req(1, 32'h7000, 4'd1);
        aw_phase(32'h7000, 4'd1, 0);
        w_burst(1, 2'b01, 4'h0, 2'b01, "b2b_write");
        send_req(0, 32'h7100, 4'd2);
        ar_phase(32'h7100, 4'd2, 0);
        r_burst(3, 1, 2'b01, -1, 32'h7700_0000, 2'b01, "b2b_read");
        n_total++;
        if (both_seen !== 1'b0) $display("FAIL b2b_ar_aw_overlap: got %b want 0", both_seen);
        else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        send_req(1, 32'h5000, 4'd3);
        aw_phase(32'h5000, 4'd3, 0);
        @(negedge ACLK);
        bus.wd_valid = 1; bus.wd_data = 32'h1; bus.wd_strb = 4'hF; bus.WREADY = 1;
        #1;
        n_total++;
        if ({bus.WVALID, bus.wd_ready, bus.WLAST} !== 3'b110)
            $display("FAIL midrst_beat1: got wvalid %b wd_ready %b wlast %b want 1 1 0",
                     bus.WVALID, bus.wd_ready, bus.WLAST);
        else n_pass++;
        @(negedge ACLK);
        bus.wd_data = 32'h2;
        ARESETn = 0;
        @(negedge ACLK);
        #1;
        n_total++;
        if ({bus.WVALID, bus.BREADY, bus.done, bus.AWVALID, bus.wd_ready} !== 5'b0)
            $display("FAIL midrst_abort: got wvalid %b bready %b done %b awvalid %b wd_ready %b want all 0",
                     bus.WVALID, bus.BREADY, bus.done, bus.AWVALID, bus.wd_ready);
        else n_pass++;
        bus.wd_valid = 0; bus.WREADY = 0;
        @(negedge ACLK);
        ARESETn = 1;
        #1;
        n_total++;
        if (bus.req_ready !== 1'b1) $display("FAIL midrst_idle: got req_ready %b want 1", bus.req_ready);
        else n_pass++;
        send_req(1, 32'h5100, 4'd0);
        aw_phase(32'h5100, 4'd0, 0);
        w_burst(0, 2'b00, 4'h0, 2'b00, "post_rst_write");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_burst();
        test_read_slverr();
        test_early_rlast();
        test_id_mismatch();
        test_back_to_back();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
